// File: rtl/mem_readback_streamer_if.sv
// Memory read port plus UART transmit byte stream used by the read-back streamer.
// master = streamer side, slave = memory / UART side.
interface mem_readback_streamer_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_dr;
  logic [7:0]            data_stream_tx;
  logic                  data_stream_tx_stb;
  logic                  data_stream_tx_ack;

  modport master (
    output mem_en, mem_we, mem_addr, data_stream_tx, data_stream_tx_stb,
    input  mem_dr, data_stream_tx_ack
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, data_stream_tx, data_stream_tx_stb,
    output mem_dr, data_stream_tx_ack
  );
endinterface

// File: rtl/mem_readback_streamer.sv
// Reads a block of 32-bit words from memory and streams each one to the UART
// as four little-endian bytes over the stb/ack handshake.
module mem_readback_streamer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  mem_readback_streamer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] remaining_reg, remaining_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]           shift_reg, shift_next;
  logic [2:0]            byte_idx_reg, byte_idx_next;
  logic                  zero_req_reg, zero_req_next;
  logic [31:0]           shifted;

  // Word moved down one byte lane; the top lane fills with zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    if (gi < 3) begin : g_move
      assign shifted[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
    end else begin : g_fill
      assign shifted[gi*8 +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      mem_addr_reg  <= '0;
      shift_reg     <= '0;
      byte_idx_reg  <= '0;
      zero_req_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      mem_addr_reg  <= mem_addr_next;
      shift_reg     <= shift_next;
      byte_idx_reg  <= byte_idx_next;
      zero_req_reg  <= zero_req_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    mem_addr_next  = mem_addr_reg;
    shift_next     = shift_reg;
    byte_idx_next  = byte_idx_reg;
    zero_req_next  = zero_req_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_next      = base_addr;
            remaining_next = word_count;
            mem_addr_next  = base_addr;
            zero_req_next  = 1'b0;
            state_next     = S_READ;
          end else begin
            zero_req_next  = 1'b1;
            state_next     = S_DONE;
          end
        end
      end
      S_READ: state_next = S_WAIT;
      S_WAIT: state_next = S_LOAD;
      S_LOAD: begin
        shift_next    = bus.mem_dr;
        byte_idx_next = 3'd0;
        state_next    = S_SEND;
      end
      S_SEND: begin
        if (bus.data_stream_tx_ack) begin
          shift_next    = shifted;
          byte_idx_next = byte_idx_reg + 3'd1;
          state_next    = S_GAP;
        end
      end
      S_GAP: begin
        if (byte_idx_reg == 3'd4) begin
          remaining_next = remaining_reg - 1'b1;
          addr_next      = addr_reg + 1'b1;
          if (remaining_reg == {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) begin
            state_next = S_DONE;
          end else begin
            // mem_addr only moves when a read is issued, wrapping naturally.
            mem_addr_next = addr_reg + 1'b1;
            state_next    = S_READ;
          end
        end else begin
          state_next = S_SEND;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.mem_en             = (state_reg == S_READ);
  assign bus.mem_we             = 1'b0;
  assign bus.mem_addr           = mem_addr_reg;
  assign bus.data_stream_tx     = shift_reg[7:0];
  assign bus.data_stream_tx_stb = (state_reg == S_SEND);
  assign done                   = (state_reg == S_DONE);
  // A zero-length request pulses done without ever raising busy.
  assign busy = (state_reg != S_IDLE) && !((state_reg == S_DONE) && zero_req_reg);

endmodule
